// File: rtl/ov7670_capture_if.sv
// Camera pixel bus in, frame-buffer write port out, for ov7670_capture.
interface ov7670_capture_if #(
    parameter int unsigned C_ADDR_W = 15
);
    logic                rgbmode;
    logic                cam_pclk;
    logic                cam_vsync;
    logic                cam_href;
    logic [7:0]          cam_data;
    logic                fb_we;
    logic [C_ADDR_W-1:0] fb_addr;
    logic [11:0]         fb_data;
    logic                frame_done;

    // Environment side: drives the camera, observes the frame buffer port.
    modport master (
        output rgbmode, cam_pclk, cam_vsync, cam_href, cam_data,
        input  fb_we, fb_addr, fb_data, frame_done
    );

    // Capture block side.
    modport slave (
        input  rgbmode, cam_pclk, cam_vsync, cam_href, cam_data,
        output fb_we, fb_addr, fb_data, frame_done
    );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: syncs the camera bus into clk, pairs bytes into pixels,
// decimates both axes and writes 12-bit pixels into the frame buffer.
module ov7670_capture #(
    parameter int unsigned C_IMG_COLS = 640,
    parameter int unsigned C_IMG_ROWS = 480,
    parameter int unsigned C_DS_SHIFT = 2,
    parameter int unsigned C_ADDR_W   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    ov7670_capture_if.slave  bus_io
);
    localparam int unsigned COL_W    = $clog2(C_IMG_COLS + 1) + 1;
    localparam int unsigned ROW_W    = $clog2(C_IMG_ROWS + 1) + 1;
    localparam int unsigned AW       = C_ADDR_W + 1;
    localparam int unsigned DS_MASK  = (1 << C_DS_SHIFT) - 1;
    localparam int unsigned ADDR_MAX = (C_IMG_COLS >> C_DS_SHIFT) * (C_IMG_ROWS >> C_DS_SHIFT) - 1;

    typedef enum logic [1:0] {S_WAIT_VS, S_VS, S_FRAME} state_t;

    logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic       vsync_s1_q, vsync_s2_q;
    logic       href_s1_q, href_s2_q, href_s3_q;
    logic [7:0] data_s1_q, data_s2_q;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                byte_sel_q, byte_sel_d;
    logic [6:0]          byte0_q, byte0_d;      // {b0[7:4], b0[2:0]}
    logic                line_has_byte_q, line_has_byte_d;
    logic                mode_q, mode_d;
    logic                fb_we_q, fb_we_d;
    logic [C_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [11:0]         fb_data_q, fb_data_d;
    logic                frame_done_q, frame_done_d;

    logic        pclk_rise_c, href_rise_c, href_fall_c, wr_ok_c;
    logic [11:0] pix_c;

    // Two-stage synchronisers, plus a third stage on pclk/href for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1_q  <= 1'b0;
            pclk_s2_q  <= 1'b0;
            pclk_s3_q  <= 1'b0;
            vsync_s1_q <= 1'b0;
            vsync_s2_q <= 1'b0;
            href_s1_q  <= 1'b0;
            href_s2_q  <= 1'b0;
            href_s3_q  <= 1'b0;
            data_s1_q  <= 8'h00;
            data_s2_q  <= 8'h00;
        end else begin
            pclk_s1_q  <= bus_io.cam_pclk;
            pclk_s2_q  <= pclk_s1_q;
            pclk_s3_q  <= pclk_s2_q;
            vsync_s1_q <= bus_io.cam_vsync;
            vsync_s2_q <= vsync_s1_q;
            href_s1_q  <= bus_io.cam_href;
            href_s2_q  <= href_s1_q;
            href_s3_q  <= href_s2_q;
            data_s1_q  <= bus_io.cam_data;
            data_s2_q  <= data_s1_q;
        end
    end

    assign pclk_rise_c = pclk_s2_q & ~pclk_s3_q;
    assign href_rise_c = href_s2_q & ~href_s3_q;
    assign href_fall_c = ~href_s2_q & href_s3_q;

    // Keep 1 of every 2^C_DS_SHIFT pixels/lines, inside the image, below the buffer end.
    assign wr_ok_c = ((col_q & COL_W'(DS_MASK)) == '0) &&
                     ((row_q & ROW_W'(DS_MASK)) == '0) &&
                     (col_q < COL_W'(C_IMG_COLS)) &&
                     (row_q < ROW_W'(C_IMG_ROWS)) &&
                     (addr_q <= AW'(ADDR_MAX));

    // RGB565 truncated to RGB444, or Y replicated to gray.
    assign pix_c = mode_q ? {byte0_q[6:3], byte0_q[2:0], data_s2_q[7], data_s2_q[4:1]}
                          : {byte0_q[6:3], byte0_q[6:3], byte0_q[6:3]};

    // Frame FSM, byte pairing, counters and write generation.
    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        addr_d          = addr_q;
        byte_sel_d      = byte_sel_q;
        byte0_d         = byte0_q;
        line_has_byte_d = line_has_byte_q;
        mode_d          = mode_q;
        fb_we_d         = 1'b0;
        fb_addr_d       = fb_addr_q;
        fb_data_d       = fb_data_q;
        frame_done_d    = 1'b0;

        case (state_q)
            S_WAIT_VS: begin
                if (vsync_s2_q) state_d = S_VS;
            end
            S_VS: begin
                if (!vsync_s2_q) begin
                    state_d         = S_FRAME;
                    col_d           = '0;
                    row_d           = '0;
                    addr_d          = '0;
                    byte_sel_d      = 1'b0;
                    line_has_byte_d = 1'b0;
                    mode_d          = bus_io.rgbmode;
                end
            end
            S_FRAME: begin
                if (vsync_s2_q) begin
                    state_d      = S_VS;
                    frame_done_d = 1'b1;
                end else if (href_fall_c) begin
                    col_d           = '0;
                    byte_sel_d      = 1'b0;
                    line_has_byte_d = 1'b0;
                    if (line_has_byte_q && (row_q != '1)) row_d = row_q + ROW_W'(1);
                end else if (pclk_rise_c && href_s2_q) begin
                    line_has_byte_d = 1'b1;
                    if (byte_sel_q && !href_rise_c) begin
                        byte_sel_d = 1'b0;
                        if (col_q != '1) col_d = col_q + COL_W'(1);
                        if (wr_ok_c) begin
                            fb_we_d   = 1'b1;
                            fb_addr_d = addr_q[C_ADDR_W-1:0];
                            fb_data_d = pix_c;
                            addr_d    = addr_q + AW'(1);
                        end
                    end else begin
                        byte0_d    = {data_s2_q[7:4], data_s2_q[2:0]};
                        byte_sel_d = 1'b1;
                    end
                end else if (href_rise_c) begin
                    byte_sel_d = 1'b0;
                end
            end
            default: state_d = S_WAIT_VS;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_WAIT_VS;
            col_q           <= '0;
            row_q           <= '0;
            addr_q          <= '0;
            byte_sel_q      <= 1'b0;
            byte0_q         <= '0;
            line_has_byte_q <= 1'b0;
            mode_q          <= 1'b0;
            fb_we_q         <= 1'b0;
            fb_addr_q       <= '0;
            fb_data_q       <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            addr_q          <= addr_d;
            byte_sel_q      <= byte_sel_d;
            byte0_q         <= byte0_d;
            line_has_byte_q <= line_has_byte_d;
            mode_q          <= mode_d;
            fb_we_q         <= fb_we_d;
            fb_addr_q       <= fb_addr_d;
            fb_data_q       <= fb_data_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign bus_io.fb_we      = fb_we_q;
    assign bus_io.fb_addr    = fb_addr_q;
    assign bus_io.fb_data    = fb_data_q;
    assign bus_io.frame_done = frame_done_q;
endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage downstream of the OV7670 controller. Once the controller has configured the sensor, this block samples the camera's pixel bus (pclk, vsync, href, 8-bit data) in the FPGA clock domain. It assembles byte pairs into pixels, decimates the image, and issues single-cycle writes of 12-bit RGB444 (or 4-bit gray replicated to 12 bits) pixels into the frame buffer. It is the producer for the frame-buffer BRAM, which feeds VGA display and object detection.

## Interface
Parameters:
- C_IMG_COLS, 640, camera active pixels per line.
- C_IMG_ROWS, 480, camera active lines per frame.
- C_DS_SHIFT, 2, decimation exponent in both axes (keep 1 of every 2^C_DS_SHIFT columns and rows); default gives 160x120.
- C_ADDR_W, 15, frame-buffer address width; must satisfy 2^C_ADDR_W ≥ (C_IMG_COLS>>C_DS_SHIFT)*(C_IMG_ROWS>>C_DS_SHIFT).

Ports:
- clk  in  1  FPGA clock, 100 MHz; must be ≥ 4× cam_pclk.
- rst_n  in  1  reset, asynchronous, active-low.
- rgbmode  in  1  1: RGB565 stream; 0: YUYV stream (Y kept as gray). Latched at frame start.
- cam_pclk  in  1  camera pixel clock (asynchronous input).
- cam_vsync  in  1  camera vsync, high between frames.
- cam_href  in  1  camera line valid.
- cam_data  in  8  camera data byte.
- fb_we  out  1  frame-buffer write strobe, one clk wide.
- fb_addr  out  C_ADDR_W  write address, row-major.
- fb_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-clk pulse at the end of each captured frame.

## Operation
- Input path: cam_pclk, cam_vsync, cam_href and cam_data pass through two flip-flop stages in clk. A third pclk stage gives edge detection. pclk_rise = s2 & ~s3. href, vsync and data are taken from stage s2 in the same cycle as pclk_rise.
- FSM:
  - S_WAIT_VS (reset state): wait for synced vsync = 1, then go to S_VS.
  - S_VS: on vsync = 0, go to S_FRAME. On entry to S_FRAME: clear col, row, addr and byte_sel; latch rgbmode.
  - S_FRAME: capture. On vsync = 1, pulse frame_done and go to S_VS.
- Byte assembly:
  - Each pclk_rise with href = 1 stores the byte; byte_sel toggles.
  - byte_sel = 0 captures byte0. byte_sel = 1 completes the pixel.
  - An href rising edge forces byte_sel = 0.
- Pixel formatting:
  - RGB565: R = b0[7:4]; G = {b0[2:0], b1[7]}; B = b1[4:1].
  - YUYV: Y = b0; fb_data = {Y[7:4], Y[7:4], Y[7:4]}.
- Counters:
  - col increments per completed pixel and clears on href falling.
  - row increments on href falling only if that line had ≥ 1 byte.
- Write condition: pixel complete AND col[C_DS_SHIFT-1:0] = 0 AND row[C_DS_SHIFT-1:0] = 0 AND col < C_IMG_COLS AND row < C_IMG_ROWS AND addr ≤ max. max = (C_IMG_COLS>>C_DS_SHIFT)*(C_IMG_ROWS>>C_DS_SHIFT) - 1.
- Address generation: addr increments after each write. There is no multiplier; row-major order follows from the decimated write order.

## Timing
- Reset values: fb_we = 0, fb_addr = 0, fb_data = 0, frame_done = 0. FSM = S_WAIT_VS; all counters and byte_sel = 0.
- Latency: a cam_pclk rising edge at the pin produces pclk_rise 3 clk later. fb_we, fb_addr and fb_data are registered and valid together 1 clk after the pclk_rise that completes the pixel. fb_addr shows the current addr; the increment takes effect on the following clk.
- fb_we is never high for 2 consecutive clks. The minimum spacing between strobes is 2 pclk periods.
- frame_done fires 1 clk after vsync = 1 is detected in S_FRAME. It fires at most once per frame.
- Boundary behaviour:
  - href falls with an odd byte count: the dangling byte is discarded; no write.
  - vsync rises mid-line: the frame ends immediately and any partial pixel is dropped.
  - Lines or pixels beyond C_IMG_ROWS or C_IMG_COLS: ignored; no write and no address change.
  - addr at max: further writes are suppressed until the next frame start.
  - rgbmode changes mid-frame: no effect until the next S_VS→S_FRAME transition.
  - Reset asserted mid-frame: outputs return to reset values immediately. After release, the block waits in S_WAIT_VS, so the partial frame is never written.
  - pclk edge in the same clk as href rising: the byte is captured as byte0.

## Test plan
- RGB565 single pixel: frame start, then one href line with bytes 0xF8, 0x1F at col 0, row 0 → one fb_we with fb_addr = 0 and fb_data = 0xF0F.
- YUYV gray: rgbmode = 0, bytes 0xA5, 0x80 → fb_data = 0xAAA. With rgbmode toggled to 1 mid-frame, the next pixel is still formatted as gray.
- Full frame with defaults: 480 lines × 640 pixels with an incrementing pattern → exactly 19200 fb_we. fb_addr runs 0..19199 with no gaps or repeats, then one frame_done.
- Decimation check: pixel (col 4, row 4) is written at addr 161; pixels at col 1–3 or row 1–3 produce no write.
- Odd bytes and overrun: a line of 3 bytes → 1 write, last byte dropped. A 481st line → no writes. A 700-pixel line → writes stop at col 639.
- Reset mid-frame: assert rst_n = 0 at row 200 → outputs 0 within 1 clk. After release, no writes occur until vsync high→low, and the next frame restarts at addr 0.
